// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: PC-select encodings,
// fetch FSM states and the IF/ID register layout with its bubble value.
package fetch_stage_pkg;

    localparam logic [1:0] PCSEL_SEQ  = 2'b00;
    localparam logic [1:0] PCSEL_RS   = 2'b01;
    localparam logic [1:0] PCSEL_JUMP = 2'b10;

    typedef enum logic [1:0] {
        ST_BOOT    = 2'b00,
        ST_RUN     = 2'b01,
        ST_HALTED  = 2'b10
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{instr: 32'h0, pc4: 32'h0, valid: 1'b0};

    // MIPS-style J/JAL target: region bits of the delay-free PC+4 plus word index
    function automatic logic [31:0] jump_target(input logic [3:0] pc_hi, input logic [25:0] idx);
        return {pc_hi, idx, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_rdata;
    logic        i_imem_ready;

    modport master (output o_imem_req, output o_imem_addr,
                    input  i_imem_rdata, input i_imem_ready);
    modport slave  (input  o_imem_req, input  o_imem_addr,
                    output i_imem_rdata, output i_imem_ready);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: stall holds, flush loads a bubble, stall wins over flush.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   stall,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= IF_ID_BUBBLE;
        else if (stall)
            q <= q;
        else if (flush)
            q <= IF_ID_BUBBLE;
        else
            q <= d;
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC selection, BOOT/RUN/HALTED control and
// the IF/ID register. Redirects resolve in ID with no delay slot.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_StallF,
    input  logic          i_StallD,
    input  logic          i_FlushD,
    input  logic          i_PCSrcD,
    input  logic [1:0]    i_pcsel,
    input  logic          i_load,
    input  logic [31:0]   i_BranchTargetD,
    input  logic [31:0]   i_RsD,
    fetch_stage_if.master imem,
    output logic [31:0]   o_InstrD,
    output logic [31:0]   o_PCPlus4D,
    output logic          o_validD,
    output logic [31:0]   o_PCF,
    output logic          o_halted
);

    fetch_state_e state;
    logic [31:0]  pcf;
    logic [31:0]  pc_plus4f;
    logic [31:0]  pc_next;
    logic [31:0]  redirect_pc;
    logic         imem_req_q;
    logic         halted_q;
    logic         run;
    logic         halt_evt;
    logic         redirect;
    logic         id_stall;
    logic         id_flush;
    if_id_t       if_id_d;
    if_id_t       if_id_q;

    assign run       = (state == ST_RUN);
    assign pc_plus4f = pcf + 32'd4;

    // ID-stage events only count for a real instruction that is moving on
    assign halt_evt = run && !i_load && if_id_q.valid && !i_StallD;
    assign redirect = run && if_id_q.valid && !i_StallD &&
                      (i_PCSrcD || (i_pcsel != PCSEL_SEQ));

    always_comb begin
        redirect_pc = if_id_q.pc4;
        if (i_PCSrcD) begin
            redirect_pc = i_BranchTargetD;
        end else begin
            case (i_pcsel)
                PCSEL_RS:   redirect_pc = i_RsD;
                PCSEL_JUMP: redirect_pc = jump_target(if_id_q.pc4[31:28], if_id_q.instr[25:0]);
                default:    redirect_pc = if_id_q.pc4;
            endcase
        end
    end

    always_comb begin
        pc_next = pcf;
        if (run && !halt_evt) begin
            if (redirect)
                pc_next = redirect_pc;
            else if (!i_StallF && imem.i_imem_ready)
                pc_next = pc_plus4f;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_BOOT;
            pcf        <= RESET_PC;
            imem_req_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pcf <= pc_next;
            case (state)
                ST_BOOT: begin
                    state      <= ST_RUN;
                    imem_req_q <= 1'b1;
                end
                ST_RUN: begin
                    if (halt_evt) begin
                        state      <= ST_HALTED;
                        imem_req_q <= 1'b0;
                        halted_q   <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_HALTED;
                    imem_req_q <= 1'b0;
                    halted_q   <= 1'b1;
                end
            endcase
        end
    end

    // Outside RUN nothing is fetched, so IF/ID bubbles and stall inputs are ignored
    assign id_stall = run && i_StallD;
    assign id_flush = !run || i_FlushD || halt_evt || redirect ||
                      i_StallF || !imem.i_imem_ready;
    assign if_id_d  = '{instr: imem.i_imem_rdata, pc4: pc_plus4f, valid: 1'b1};

    if_id_reg u_if_id (
        .clk   (clk),
        .rst   (rst),
        .stall (id_stall),
        .flush (id_flush),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign imem.o_imem_req  = imem_req_q;
    assign imem.o_imem_addr = pcf;
    assign o_InstrD         = if_id_q.instr;
    assign o_PCPlus4D       = if_id_q.pc4;
    assign o_validD         = if_id_q.valid;
    assign o_PCF            = pcf;
    assign o_halted         = halted_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-003 SHALL provide i_StallF  input  1  hold the PC (hazard unit).
REQ-004 SHALL provide i_StallD  input  1  hold the IF/ID register.
REQ-005 SHALL provide i_FlushD  input  1  load a bubble into IF/ID.
REQ-006 SHALL provide i_PCSrcD  input  1  conditional branch taken in ID.
REQ-007 SHALL provide i_pcsel  input  2  decoder PC select: 00 sequential, 01 register Rs, 10 jump target.
REQ-008 SHALL provide i_load  input  1  decoder run enable; 0 means HALT is in ID.
REQ-009 SHALL provide i_BranchTargetD  input  32  branch target computed in ID.
REQ-010 SHALL provide i_RsD  input  32  forwarded Rs value for JR/JALR.
REQ-011 SHALL provide o_imem_req  output  1  fetch request; o_imem_addr  output  32  fetch address (= PCF).
REQ-012 SHALL provide i_imem_rdata  input  32  instruction word; i_imem_ready  input  1  rdata valid this cycle.
REQ-013 SHALL provide o_InstrD  output  32, o_PCPlus4D  output  32, o_validD  output  1: the IF/ID register contents.
REQ-014 SHALL provide o_PCF  output  32  current PC; o_halted  output  1  core halted.

Function
REQ-015 SHALL implement FSM BOOT -> RUN -> HALTED; BOOT lasts exactly one cycle after reset with o_imem_req=0.
REQ-016 In RUN, o_imem_req SHALL be 1, and a fetch SHALL complete in the cycle that i_imem_ready=1 (zero-wait memory gives 1 instruction per cycle).
REQ-017 Jump target SHALL be {o_PCPlus4D[31:28], o_InstrD[25:0], 2'b00}; PC+4 SHALL wrap modulo 2^32.
REQ-018 A redirect SHALL be active when o_validD=1, i_StallD=0, and either i_PCSrcD=1 or i_pcsel!=00. Redirect is ignored while i_StallD=1.
REQ-019 Next-PC priority SHALL be: rst, then halt, then redirect (PCSrcD -> i_BranchTargetD; pcsel 01 -> i_RsD; pcsel 10 -> jump target; PCSrcD wins over pcsel), then i_StallF (hold), then !i_imem_ready (hold), then PCF+4.
REQ-020 A redirect SHALL overrule i_StallF and i_imem_ready=0. The wrong-path fetch in IF SHALL be discarded: IF/ID receives a bubble next cycle. There is no delay slot.
REQ-021 A bubble SHALL be o_InstrD=0, o_PCPlus4D=0, o_validD=0.
REQ-022 IF/ID update priority SHALL be: rst, then i_StallD (hold), then i_FlushD, halt, or redirect (bubble), then i_StallF or !i_imem_ready (bubble), then load {i_imem_rdata, PCF+4, valid=1}.
REQ-023 Halt SHALL occur when i_load=0, o_validD=1 and i_StallD=0. The FSM goes to HALTED next cycle: PC frozen, o_imem_req=0, IF/ID bubbled, o_halted=1.
REQ-024 HALTED SHALL be left only by rst. All stall, flush and redirect inputs SHALL be ignored in HALTED.
REQ-025 When i_imem_ready rises in the same cycle as a redirect, the fetched word SHALL be discarded.

Reset
REQ-026 On rst=1 at a clock edge: PCF=RESET_PC, FSM=BOOT, o_InstrD=0, o_PCPlus4D=0, o_validD=0, o_halted=0, o_imem_req=0. Reset SHALL win over any event in the same cycle, including an in-flight fetch, redirect or halt.

Structure
REQ-027 The pcsel encodings (00/01/10), the FSM state encodings, and the bubble constant SHALL live in the shared pipeline package.
REQ-028 The IF/ID register (with stall and flush) SHALL be the sub-module if_id_reg. The PC register, next-PC mux and FSM SHALL stay in fetch_stage.

Verification
REQ-029 Reset with RESET_PC=0, zero-wait memory -> BOOT for 1 cycle, then PCF 0,4,8,...; o_validD=1 from the 3rd cycle with o_PCPlus4D=4.
REQ-030 BEQ in ID at PC 0x10 with i_PCSrcD=1, target 0x40 -> next PCF=0x40; IF/ID holds a bubble for 1 cycle; next valid instruction has o_PCPlus4D=0x44.
REQ-031 J with InstrD[25:0]=0x100 and PCPlus4D=0x1000_0008 -> PCF=0x1000_0400. JR (pcsel=01) with Rs=0x200 -> PCF=0x200.
REQ-032 i_imem_ready=0 for 3 cycles at PC 0x20 -> PCF holds 0x20 and o_validD=0 for 3 cycles, then the 0x20 instruction enters ID. A redirect during the wait -> PCF=target and the late word is dropped.
REQ-033 i_StallF=i_StallD=1 for 2 cycles -> PCF and IF/ID unchanged; a redirect asserted during the stall has no effect.
REQ-034 HALT (i_load=0) in ID -> o_halted=1 next cycle, o_imem_req=0, PC frozen under any stimulus; rst -> PCF=RESET_PC and BOOT.
